// File: rtl/adder_accumulator.sv
// Streaming signed accumulator built around a 32-bit ripple-carry adder.
// Optional saturation on overflow; result is offered with a sticky overflow flag.

module rippleCarryAdder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);
  logic carry;
  logic carry_msb;

  always_comb begin
    carry     = cin;
    carry_msb = 1'b0;
    sum       = '0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) carry_msb = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  // Signed overflow: carry into the sign bit differs from the carry out of it.
  assign cout     = carry;
  assign overflow = carry ^ carry_msb;
endmodule

module adder_accumulator #(
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_overflow,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [31:0]      acc;
  logic             ovf;
  logic [CNT_W-1:0] remaining;
  logic [31:0]      add_sum;
  logic             add_ovf;
  logic             unused_cout;
  logic [31:0]      acc_next;
  logic             accept;

  rippleCarryAdder #(.W(32)) u_adder (
    .a        (acc),
    .b        (in_data),
    .cin      (1'b0),
    .sum      (add_sum),
    .cout     (unused_cout),
    .overflow (add_ovf)
  );

  assign accept = (state == ACCUM) && in_valid;

  // Overflow direction always matches the sign of the incoming sample.
  always_comb begin
    acc_next = add_sum;
    if (SATURATE && add_ovf)
      acc_next = in_data[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && remaining == CNT_W'(1)) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else if (state == IDLE && start) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= len;
    end else if (accept) begin
      acc       <= acc_next;
      ovf       <= ovf | add_ovf;
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign out_sum      = acc;
  assign out_overflow = ovf;
endmodule

// File: tb/tb_adder_accumulator.sv
// Scoreboard bench: wrapping and saturating instances driven in lockstep and
// compared against an arithmetic reference model of the accumulation rules.

module tb_adder_accumulator;
  localparam int CNT_W = 8;
  localparam longint MAX32 = 64'sd2147483647;
  localparam longint MIN32 = -64'sd2147483648;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
  } result_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = '0;
  logic             out_ready = 1'b0;

  logic        wrap_in_ready, wrap_out_valid, wrap_out_overflow, wrap_busy;
  logic [31:0] wrap_out_sum;
  logic        sat_in_ready, sat_out_valid, sat_out_overflow, sat_busy;
  logic [31:0] sat_out_sum;

  result_t exp_wrap[$];
  result_t exp_sat[$];
  int      samples[$];
  int      tests = 0;
  int      fails = 0;

  adder_accumulator #(.SATURATE(1'b0), .CNT_W(CNT_W)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(wrap_in_ready), .in_data(in_data),
    .out_valid(wrap_out_valid), .out_ready(out_ready), .out_sum(wrap_out_sum),
    .out_overflow(wrap_out_overflow), .busy(wrap_busy)
  );

  adder_accumulator #(.SATURATE(1'b1), .CNT_W(CNT_W)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_sum(sat_out_sum),
    .out_overflow(sat_out_overflow), .busy(sat_busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  // Reference model: exact 64-bit sums, then wrap or clamp to the 32-bit range.
  task automatic push_expected(input int n, output result_t ew, output result_t es);
    longint wsum = 0;
    longint ssum = 0;
    logic   wo = 1'b0;
    logic   so = 1'b0;
    for (int i = 0; i < n; i++) begin
      longint t;
      t = wsum + longint'(samples[i]);
      if (t > MAX32 || t < MIN32) wo = 1'b1;
      wsum = longint'(int'(t));
      t = ssum + longint'(samples[i]);
      if (t > MAX32) begin
        so = 1'b1; ssum = MAX32;
      end else if (t < MIN32) begin
        so = 1'b1; ssum = MIN32;
      end else ssum = t;
    end
    ew.sum = wsum[31:0]; ew.ovf = wo;
    es.sum = ssum[31:0]; es.ovf = so;
    exp_wrap.push_back(ew);
    exp_sat.push_back(es);
  endtask

  // gap < 0 picks a random 0..2 idle cycles before each sample.
  task automatic apply_stimulus(input int n, input int gap, input int hold,
                                input bit start_in_done);
    result_t ew, es;
    push_expected(n, ew, es);
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    len   = CNT_W'($urandom);
    check_output("busy_after_start", {31'b0, wrap_busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        @(negedge clk);
        check_output("stall_in_ready", {31'b0, wrap_in_ready}, 32'd1);
      end
      in_valid = 1'b1;
      in_data  = samples[i];
      check_output("accum_in_ready", {31'b0, sat_in_ready}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_output("wrap_valid_latency", {31'b0, wrap_out_valid}, 32'd1);
    check_output("sat_valid_latency", {31'b0, sat_out_valid}, 32'd1);
    check_output("done_in_ready", {31'b0, wrap_in_ready}, 32'd0);
    repeat (hold) begin
      start = start_in_done;
      @(negedge clk);
      check_output("hold_valid", {31'b0, wrap_out_valid}, 32'd1);
      check_output("hold_wrap_sum", wrap_out_sum, ew.sum);
      check_output("hold_sat_sum", sat_out_sum, es.sum);
    end
    out_ready = 1'b1;
    start     = start_in_done;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check_output("idle_after_ready", {30'b0, wrap_busy, wrap_out_valid}, 32'd0);
    check_output("sat_idle_after_ready", {30'b0, sat_busy, sat_out_valid}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_wrap_ctl"},
                 {28'b0, wrap_in_ready, wrap_out_valid, wrap_out_overflow, wrap_busy}, 32'd0);
    check_output({tag, "_wrap_sum"}, wrap_out_sum, 32'd0);
    check_output({tag, "_sat_ctl"},
                 {28'b0, sat_in_ready, sat_out_valid, sat_out_overflow, sat_busy}, 32'd0);
    check_output({tag, "_sat_sum"}, sat_out_sum, 32'd0);
  endtask

  task automatic apply_reset_mid_run();
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(5);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h7000_0000 + $urandom_range(1000, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    result_t e;
    #1;
    if (rst_n && out_ready) begin
      if (wrap_out_valid) begin
        if (exp_wrap.size() == 0) check_output("wrap_unexpected_out", 32'd1, 32'd0);
        else begin
          e = exp_wrap.pop_front();
          check_output("wrap_sum", wrap_out_sum, e.sum);
          check_output("wrap_ovf", {31'b0, wrap_out_overflow}, {31'b0, e.ovf});
        end
      end
      if (sat_out_valid) begin
        if (exp_sat.size() == 0) check_output("sat_unexpected_out", 32'd1, 32'd0);
        else begin
          e = exp_sat.pop_front();
          check_output("sat_sum", sat_out_sum, e.sum);
          check_output("sat_ovf", {31'b0, sat_out_overflow}, {31'b0, e.ovf});
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    samples = '{100, -50, 200};
    apply_stimulus(3, 0, 0, 1'b0);
    samples = '{2147483647, 1};
    apply_stimulus(2, 0, 0, 1'b0);
    samples = '{int'(32'h8000_0000), -1};
    apply_stimulus(2, 0, 1, 1'b0);
    samples = '{2147483647, 1, 2147483647};
    apply_stimulus(3, 1, 0, 1'b0);
    samples = '{-100, -200, 150, 150};
    apply_stimulus(4, 2, 5, 1'b1);
    samples = '{};
    apply_stimulus(0, 0, 0, 1'b0);

    apply_reset_mid_run();
    samples = '{50, 75};
    apply_stimulus(2, 0, 0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      int n;
      n = int'($urandom_range(10, 1));
      samples = '{};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(1, 0) == 1) samples.push_back(int'($urandom));
        else samples.push_back(int'($urandom_range(2000, 0)) - 1000);
      end
      apply_stimulus(n, -1, int'($urandom_range(3, 0)), r[0]);
    end

    repeat (5) @(negedge clk);
    check_output("wrap_queue_drained", exp_wrap.size(), 32'd0);
    check_output("sat_queue_drained", exp_sat.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
